// File: rtl/regfile_dump_reader_if.sv
// Handshake and bus bundle for regfile_dump_reader: control strobes, the
// register-file read port, the (index, data) output stream and status.
interface regfile_dump_reader_if #(
    parameter int SEL_W  = 5,
    parameter int DATA_W = 32
);
    // Control
    logic              start;
    logic [SEL_W-1:0]  first_sel;
    logic [SEL_W-1:0]  last_sel;

    // Register-file read port
    logic [SEL_W-1:0]  rd_select;
    logic [DATA_W-1:0] rd_data;

    // Output beat stream
    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  out_index;
    logic [DATA_W-1:0] out_data;

    // Status
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    // The dump reader itself.
    modport master (
        input  start, first_sel, last_sel, rd_data, out_ready,
        output rd_select, out_valid, out_index, out_data, busy, done, checksum
    );

    // The environment: requester, register file and beat consumer.
    modport slave (
        output start, first_sel, last_sel, rd_data, out_ready,
        input  rd_select, out_valid, out_index, out_data, busy, done, checksum
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive, wrapping range of register indices through one
// register-file read port and streams each word out as an (index, data)
// beat over valid/ready, accumulating an XOR checksum of accepted beats.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_dump_reader_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [SEL_W-1:0] LAST_INDEX = SEL_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [SEL_W-1:0]  last_q;
    logic [SEL_W-1:0]  rd_select_q;
    logic [SEL_W-1:0]  out_index_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] checksum_q;
    logic [SEL_W-1:0]  next_index;

    // Successor of the current beat's index, wrapping past the top register.
    assign next_index = (out_index_q == LAST_INDEX) ? '0 : out_index_q + 1'b1;

    // Sequencer: latch the range, capture one word per READ, hold it in SEND
    // until accepted, then either advance or finish.
    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            last_q      <= '0;
            rd_select_q <= '0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            checksum_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        last_q      <= bus.last_sel;
                        rd_select_q <= bus.first_sel;
                        checksum_q  <= '0;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    out_data_q  <= bus.rd_data;
                    out_index_q <= rd_select_q;
                    out_valid_q <= 1'b1;
                    state       <= S_SEND;
                end
                S_SEND: begin
                    if (out_valid_q && bus.out_ready) begin
                        checksum_q  <= checksum_q ^ out_data_q;
                        out_valid_q <= 1'b0;
                        if (out_index_q == last_q) begin
                            state <= S_DONE;
                        end else begin
                            rd_select_q <= next_index;
                            state       <= S_READ;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status is a pure decode of the registered state.
    // NOTE: continuous assigns of registered state cannot infer latches.
    assign bus.busy      = (state == S_READ) || (state == S_SEND);
    assign bus.done      = (state == S_DONE);
    assign bus.rd_select = rd_select_q;
    assign bus.out_index = out_index_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.checksum  = checksum_q;

endmodule
